// File: rtl/miriscv_arb_pkg.sv
// rtl/miriscv_arb_pkg.sv - shared types and widths for the miriscv memory arbiter
package miriscv_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  typedef enum logic {
    ARB_INSTR = 1'b0,
    ARB_DATA  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [ARB_BE_W-1:0]   be;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_slot_t;

  localparam int ARB_SLOT_W = $bits(arb_slot_t);

endpackage

// File: rtl/miriscv_arb_slot.sv
// rtl/miriscv_arb_slot.sv - one-entry request capture register with full flag
// A load in the same cycle as a clear refills the slot, so back-to-back requests are not lost.
module miriscv_arb_slot
  import miriscv_arb_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [ARB_SLOT_W-1:0] data_i,
  output logic                  full_o,
  output logic [ARB_SLOT_W-1:0] data_o,
  output logic                  viol_o
);

  logic                  full_q, full_d;
  logic [ARB_SLOT_W-1:0] data_q, data_d;
  logic                  accept;

  assign accept = load_i && (!full_q || clear_i);
  assign viol_o = load_i && full_q && !clear_i;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear_i) full_d = 1'b0;
    if (accept) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// rtl/miriscv_mem_arbiter.sv - serialises miriscv instr/data requests onto one req/gnt/rvalid memory port
// Optional MIRISCV_ARB_RR_EN: round-robin between the two slots instead of data-first priority.
module miriscv_mem_arbiter
  import miriscv_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic                instr_req_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  output logic                instr_rvalid_o,
  output logic [DATA_W-1:0]   instr_rdata_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  arb_slot_t instr_in, data_in, instr_slot, data_slot, sel_slot;
  logic      instr_full, data_full, instr_viol, data_viol;
  logic      launch, resp_fire;
  state_e    state_q;
  owner_e    owner_q, win, sel;

  always_comb begin
    instr_in       = '0;
    instr_in.be    = '1;
    instr_in.addr  = instr_addr_i;
    data_in.we     = data_we_i;
    data_in.be     = data_be_i;
    data_in.addr   = data_addr_i;
    data_in.wdata  = data_wdata_i;
  end

  miriscv_arb_slot u_instr_slot (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .load_i  (instr_req_i),
    .clear_i (resp_fire && (owner_q == ARB_INSTR)),
    .data_i  (instr_in),
    .full_o  (instr_full),
    .data_o  (instr_slot),
    .viol_o  (instr_viol)
  );

  miriscv_arb_slot u_data_slot (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .load_i  (data_req_i),
    .clear_i (resp_fire && (owner_q == ARB_DATA)),
    .data_i  (data_in),
    .full_o  (data_full),
    .data_o  (data_slot),
    .viol_o  (data_viol)
  );

  assign launch    = (state_q == ARB_IDLE) && (instr_full || data_full);
  assign resp_fire = (state_q == ARB_RESP) && mem_rvalid_i;

`ifdef MIRISCV_ARB_RR_EN
  owner_e last_q;

  always_comb begin
    if (instr_full && data_full) win = (last_q == ARB_DATA) ? ARB_INSTR : ARB_DATA;
    else                         win = data_full ? ARB_DATA : ARB_INSTR;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)    last_q <= ARB_DATA;
    else if (launch) last_q <= win;
  end
`else
  assign win = data_full ? ARB_DATA : ARB_INSTR;
`endif

  // The slots stay stable while full, so the memory fields are read straight from them.
  assign sel      = (state_q == ARB_IDLE) ? win : owner_q;
  assign sel_slot = (sel == ARB_DATA) ? data_slot : instr_slot;

  assign mem_req_o   = launch || (state_q == ARB_REQ);
  assign mem_we_o    = sel_slot.we;
  assign mem_be_o    = sel_slot.be;
  assign mem_addr_o  = sel_slot.addr;
  assign mem_wdata_o = sel_slot.wdata;

  assign instr_rvalid_o = resp_fire && (owner_q == ARB_INSTR);
  assign data_rvalid_o  = resp_fire && (owner_q == ARB_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= ARB_IDLE;
      owner_q <= ARB_INSTR;
    end else begin
      case (state_q)
        ARB_IDLE: if (launch) begin
          owner_q <= win;
          state_q <= mem_gnt_i ? ARB_RESP : ARB_REQ;
        end
        ARB_REQ:  if (mem_gnt_i) state_q <= ARB_RESP;
        ARB_RESP: if (mem_rvalid_i) state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

  always @(posedge clk_i) begin
    if (arstn_i) begin
      assert (!instr_viol) else $warning("instr request dropped: slot still occupied");
      assert (!data_viol) else $warning("data request dropped: slot still occupied");
    end
  end

endmodule

// File: doc/miriscv_mem_arbiter.md
Name: miriscv_mem_arbiter

Overview:
Shares one single-port memory between the miriscv core's instruction and data interfaces. The core issues requests without a grant handshake. The block captures each request in a per-port one-entry slot and serialises the slots onto a req/gnt/rvalid memory port, one outstanding transaction at a time. It routes each response back to the owning core port. It sits between the core (or miriscv_tracing) and the memory model in the testbench and in integration tops.

Parameters:
ADDR_W  32  address width
DATA_W  32  data width; byte-enable width is DATA_W/8

Ports:
clk_i           in   1         clock
arstn_i         in   1         asynchronous active-low reset
instr_req_i     in   1         core instruction fetch request
instr_addr_i    in   ADDR_W    fetch address
instr_rvalid_o  out  1         fetch response valid
instr_rdata_o   out  DATA_W    fetch data
data_req_i      in   1         core data request
data_we_i       in   1         1 = store
data_be_i       in   DATA_W/8  byte enables
data_addr_i     in   ADDR_W    data address
data_wdata_i    in   DATA_W    store data
data_rvalid_o   out  1         data response valid (loads and stores)
data_rdata_o    out  DATA_W    load data
mem_req_o       out  1         memory request
mem_gnt_i       in   1         memory grant
mem_we_o        out  1         memory write enable
mem_be_o        out  DATA_W/8  memory byte enables
mem_addr_o      out  ADDR_W    memory address
mem_wdata_o     out  DATA_W    memory write data
mem_rvalid_i    in   1         memory response valid
mem_rdata_i     in   DATA_W    memory read data

Behaviour:
- Reset values:
  - All *_rvalid_o, mem_req_o and mem_we_o are 0.
  - mem_be_o, mem_addr_o and mem_wdata_o are 0.
  - Both slots are empty; FSM is IDLE; owner is INSTR.
- Slot capture:
  - When a port's req is 1 and its slot is empty, that cycle's request fields are latched and the slot is marked full.
  - The slot empties on the cycle the matching response is forwarded.
  - A req while the slot is full is a protocol violation. It is dropped and the slot is unchanged; a simulation assertion fires.
- FSM states: IDLE, REQ, RESP.
  - IDLE: if any slot is full, select a winner, drive mem_* from the winner's slot registers, set mem_req_o=1 and move to REQ. A slot filled in cycle N is eligible in IDLE at N+1.
  - REQ: mem_req_o and the mem_* fields are held stable until mem_gnt_i=1. On grant, mem_req_o drops to 0 in the next cycle and the FSM moves to RESP.
  - RESP: wait for mem_rvalid_i. In the rvalid cycle, forward combinationally to the owner (owner_rvalid_o=1, owner_rdata_o=mem_rdata_i), clear the owner's slot and return to IDLE.
- Non-owner rvalid_o is 0. rdata_o is mem_rdata_i on both ports and is qualified only by rvalid.
- mem_rvalid_i outside RESP is ignored.
- Arbitration is fixed priority: data before instr. The winner is chosen only in IDLE and is locked until RESP completes.
- Simultaneous events:
  - Both reqs in the same cycle: both are latched; data is served first and instr next. Instr has minimum extra latency equal to the data transaction's length.
  - A new req on a port in its own rvalid cycle is captured, because the slot clears and fills in the same cycle.
- Minimum latency: req at cycle N, mem_req_o=1 at N+1, gnt at N+1, rvalid at N+2 forwarded at N+2.
- Reset mid-transaction: everything returns to reset values immediately; pending slots are discarded; no responses are produced.

Optional Feature:
MIRISCV_ARB_RR_EN
- Defined: two-way round-robin replaces fixed priority. The port that did not win last has priority when both slots are full. The last-winner register resets to DATA, so instr wins the first tie.
- Undefined: fixed data-over-instr priority; no last-winner register.

Decomposition:
- Package miriscv_arb_pkg:
  - owner_e {ARB_INSTR, ARB_DATA}
  - state_e {ARB_IDLE, ARB_REQ, ARB_RESP}
  - packed struct arb_slot_t {we, be, addr, wdata}, using default widths
- Sub-module miriscv_arb_slot: a one-entry capture register with full flag, load/clear and a violation flag. It is instantiated twice; the instr instance ties we=0 and be=all-ones.

Test Plan:
1. instr_req=1, addr=0x80 for 1 cycle; memory grants immediately and returns rvalid one cycle later with 0x00000013 -> mem_addr_o=0x80 at N+1; instr_rvalid_o=1 with rdata 0x13 at N+2; data_rvalid_o stays 0.
2. instr_req (0x100) and data load (0x2000) in the same cycle -> mem_addr_o=0x2000 first, then 0x100. Responses go data then instr. With MIRISCV_ARB_RR_EN, instr 0x100 goes first after reset.
3. Store be=4'b0011, addr=0x2004, wdata=0xDEADBEEF; gnt held low 3 cycles -> mem_req_o and fields stable for 4 cycles; mem_we_o=1; data_rvalid_o pulses once.
4. Second instr_req while instr slot full -> request dropped, assertion fires, exactly one instr_rvalid_o pulse.
5. arstn_i=0 during RESP, then a late mem_rvalid_i -> all outputs 0, no rvalid forwarded, FSM IDLE after release.
6. Back-to-back fetches: each new instr_req is issued in its rvalid cycle -> one memory transaction every 2 cycles sustained with zero-wait memory.
